score_controller: RTL and testbench
===================================

// Module: score_controller
// PURPOSE
//  Game-state controller for the scoreboard. Turns three debounced push-button levels
//  (P1 point, P2 point, undo/new-game) into two BCD scores 00..99, and decides the winner.
//  Arbitrates between the two player buttons and applies a win-by-margin rule.
//  Its score outputs drive the p1/p2 tens/ones inputs of the display controller,
//  and its winner outputs drive the game-over indication.
// PARAMETERS
//  WIN_SCORE   21    minimum points needed to win
//  WIN_MARGIN  2     required lead over the opponent at win time
//  LOCKOUT     200   cycles (ms) after an accepted event during which all button rises are ignored
//  HOLD_TIME   2000  cycles (ms) undo must be held continuously to start a new game
// PORTS
//  clk_1khz     in   1  1 kHz system clock
//  rst_ni       in   1  asynchronous reset, active low
//  p1_btn_i     in   1  P1 point button, debounced level, active high
//  p2_btn_i     in   1  P2 point button, debounced level, active high
//  undo_btn_i   in   1  undo-last-point / hold for new game, debounced level
//  p1_tens_o    out  4  P1 score tens digit, BCD 0..9
//  p1_ones_o    out  4  P1 score ones digit, BCD 0..9
//  p2_tens_o    out  4  P2 score tens digit, BCD 0..9
//  p2_ones_o    out  4  P2 score ones digit, BCD 0..9
//  winner_o     out  2  00 none, 01 P1, 10 P2 (11 never driven)
//  game_over_o  out  1  high while in GAME_OVER
//  point_o      out  1  one-cycle pulse per accepted point (for buzzer/LED)
// BEHAVIOUR
//  - Reset (rst_ni=0, async): all scores 0; winner_o=00; game_over_o=0; point_o=0.
//    Internal state: state=PLAY, last_scorer=none, lockout/hold counters=0, edge registers=0.
//  - Edge detection: rise_x = btn_x & ~btn_x_q. The btn_x_q flops update every cycle.
//  - All outputs are registered and change on the same edge that samples the input rise.
//    Latency is therefore 1 cycle.
//  - Lockout: any accepted event (point or undo) loads lockout counter = LOCKOUT.
//    While it is nonzero it decrements, and every rise is discarded (rises are not queued).
//  - Priority within one cycle: undo rise > point rises.
//    If p1 and p2 rise together, the player who did NOT score the last accepted point wins.
//    If last_scorer=none, P1 wins. The losing rise is dropped.
//  - States:
//    PLAY -> GAME_OVER on a point where new score >= WIN_SCORE and new score - other >= WIN_MARGIN.
//      winner_o is set in the same cycle.
//    GAME_OVER: point rises are ignored.
//    GAME_OVER -> PLAY on undo (winner_o cleared) or on new game.
//  - Point: BCD increment; ones 9->0 with tens+1. Saturation at 99:
//    the press is ignored, no point_o, last_scorer unchanged.
//    Otherwise last_scorer<=player and point_o=1.
//    A 7-bit binary shadow count per player is used for the win comparison.
//  - Undo (rise): one-deep history. If last_scorer != none, decrement that player's score.
//    BCD ones 0->9 with tens-1. Then last_scorer<=none.
//    If last_scorer = none: no-op, lockout not loaded.
//  - New game: hold counter increments while undo_btn_i=1 and clears on release.
//    At count HOLD_TIME-1: scores 0, winner 00, state PLAY, last_scorer none, lockout loaded.
//    The counter then saturates and does not retrigger until release.
//    The initial rise of a long press also performs an undo first.
//  - New game works in any state and overrides any simultaneous point rise.
//  - Reset asserted mid-lockout or mid-hold aborts it; nothing resumes after release.
// TESTING
//  1 Reset, then 3 P1 presses spaced 300 cycles -> p1=03, p2=00, three point_o pulses, winner 00.
//  2 P1 at 09, press P1 -> p1_tens=1, p1_ones=0.
//    A second P1 press 50 cycles later (in lockout) -> no change.
//  3 Simultaneous P1+P2 rise:
//    after last_scorer=P1 -> P2 scores; from reset (none) -> P1 scores.
//  4 Score 20-19, P1 point -> 21-19, game_over=1, winner=01.
//    Further P2 press -> no change. Undo -> 20-19, game_over=0.
//  5 Score 21-20 (no win): P1 point -> 22-20 win.
//    Separately, at 99-98 a P1 press -> no change, no point_o.
//  6 Hold undo 2000 cycles at 05-07, last=P2 -> undo to 05-06 at rise, then 00-00 at cycle 1999.
//    Continued hold -> no retrigger. rst_ni pulse mid-hold -> all cleared immediately.

Source files
------------

// File: rtl/score_controller.sv
// Scoreboard game-state controller: button edges -> BCD scores, winner decision,
// lockout after accepted events, one-deep undo and hold-to-restart.
module score_controller #(
    parameter int unsigned WIN_SCORE  = 21,
    parameter int unsigned WIN_MARGIN = 2,
    parameter int unsigned LOCKOUT    = 200,
    parameter int unsigned HOLD_TIME  = 2000
) (
    input  logic       clk_1khz,
    input  logic       rst_ni,
    input  logic       p1_btn_i,
    input  logic       p2_btn_i,
    input  logic       undo_btn_i,
    output logic [3:0] p1_tens_o,
    output logic [3:0] p1_ones_o,
    output logic [3:0] p2_tens_o,
    output logic [3:0] p2_ones_o,
    output logic [1:0] winner_o,
    output logic       game_over_o,
    output logic       point_o
);

    localparam int unsigned LW = $clog2(LOCKOUT + 1);
    localparam int unsigned HW = $clog2(HOLD_TIME + 1);
    localparam int unsigned SW = 7;

    typedef enum logic {S_PLAY = 1'b0, S_GAME_OVER = 1'b1} state_t;
    typedef enum logic [1:0] {LAST_NONE = 2'b00, LAST_P1 = 2'b01, LAST_P2 = 2'b10} scorer_t;

    state_t        state_q, state_d;
    scorer_t       last_q, last_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          p1_q, p2_q, undo_q;
    logic [7:0]    p1_bcd_q, p1_bcd_d, p2_bcd_q, p2_bcd_d;
    logic [SW-1:0] p1_bin_q, p1_bin_d, p2_bin_q, p2_bin_d;
    logic [1:0]    winner_q, winner_d;
    logic          point_q, point_d;

    logic          rise_p1, rise_p2, rise_undo, lock_active, new_game;
    logic          pick_p1, pick_p2;
    logic [SW-1:0] sel_bin, oth_bin, new_bin;
    logic          win;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign rise_p1   = p1_btn_i & ~p1_q;
    assign rise_p2   = p2_btn_i & ~p2_q;
    assign rise_undo = undo_btn_i & ~undo_q;

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        lock_d   = lock_q;
        hold_d   = '0;
        p1_bcd_d = p1_bcd_q;
        p2_bcd_d = p2_bcd_q;
        p1_bin_d = p1_bin_q;
        p2_bin_d = p2_bin_q;
        winner_d = winner_q;
        point_d  = 1'b0;

        lock_active = (lock_q != '0);
        if (lock_active) lock_d = lock_q - LW'(1);

        // Counter saturates at HOLD_TIME so a long hold triggers only once
        if (undo_btn_i) hold_d = (hold_q == HW'(HOLD_TIME)) ? hold_q : hold_q + HW'(1);
        new_game = undo_btn_i && (hold_q == HW'(HOLD_TIME - 1));

        // Simultaneous rises go to the player who did not score last
        pick_p1 = rise_p1 && (!rise_p2 || last_q != LAST_P1);
        pick_p2 = rise_p2 && !pick_p1;

        sel_bin = pick_p1 ? p1_bin_q : p2_bin_q;
        oth_bin = pick_p1 ? p2_bin_q : p1_bin_q;
        new_bin = sel_bin + SW'(1);
        win     = ({1'b0, new_bin} >= 8'(WIN_SCORE)) &&
                  ({1'b0, new_bin} >= {1'b0, oth_bin} + 8'(WIN_MARGIN));

        if (!lock_active) begin
            if (rise_undo) begin
                if (last_q != LAST_NONE) begin
                    if (last_q == LAST_P1) begin
                        p1_bcd_d = bcd_dec(p1_bcd_q);
                        p1_bin_d = p1_bin_q - SW'(1);
                    end else begin
                        p2_bcd_d = bcd_dec(p2_bcd_q);
                        p2_bin_d = p2_bin_q - SW'(1);
                    end
                    last_d   = LAST_NONE;
                    lock_d   = LW'(LOCKOUT);
                    state_d  = S_PLAY;
                    winner_d = 2'b00;
                end
            end else if ((pick_p1 || pick_p2) && state_q == S_PLAY && sel_bin != SW'(99)) begin
                if (pick_p1) begin
                    p1_bcd_d = bcd_inc(p1_bcd_q);
                    p1_bin_d = new_bin;
                    last_d   = LAST_P1;
                end else begin
                    p2_bcd_d = bcd_inc(p2_bcd_q);
                    p2_bin_d = new_bin;
                    last_d   = LAST_P2;
                end
                point_d = 1'b1;
                lock_d  = LW'(LOCKOUT);
                if (win) begin
                    state_d  = S_GAME_OVER;
                    winner_d = pick_p1 ? 2'b01 : 2'b10;
                end
            end
        end

        // New game overrides everything else in this cycle
        if (new_game) begin
            state_d  = S_PLAY;
            last_d   = LAST_NONE;
            lock_d   = LW'(LOCKOUT);
            p1_bcd_d = '0;
            p2_bcd_d = '0;
            p1_bin_d = '0;
            p2_bin_d = '0;
            winner_d = 2'b00;
            point_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_1khz or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_PLAY;
            last_q   <= LAST_NONE;
            lock_q   <= '0;
            hold_q   <= '0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            undo_q   <= 1'b0;
            p1_bcd_q <= '0;
            p2_bcd_q <= '0;
            p1_bin_q <= '0;
            p2_bin_q <= '0;
            winner_q <= 2'b00;
            point_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            lock_q   <= lock_d;
            hold_q   <= hold_d;
            p1_q     <= p1_btn_i;
            p2_q     <= p2_btn_i;
            undo_q   <= undo_btn_i;
            p1_bcd_q <= p1_bcd_d;
            p2_bcd_q <= p2_bcd_d;
            p1_bin_q <= p1_bin_d;
            p2_bin_q <= p2_bin_d;
            winner_q <= winner_d;
            point_q  <= point_d;
        end
    end

    assign p1_tens_o   = p1_bcd_q[7:4];
    assign p1_ones_o   = p1_bcd_q[3:0];
    assign p2_tens_o   = p2_bcd_q[7:4];
    assign p2_ones_o   = p2_bcd_q[3:0];
    assign winner_o    = winner_q;
    assign game_over_o = (state_q == S_GAME_OVER);
    assign point_o     = point_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed testbench for score_controller: scoring, arbitration, win rules, undo, new game.
module tb_score_controller;

    localparam int unsigned LOCKOUT = 200;

    logic       clk_1khz = 1'b0;
    logic       rst_ni = 1'b0;
    logic       p1_btn_i = 1'b0, p2_btn_i = 1'b0, undo_btn_i = 1'b0;
    logic [3:0] p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o;
    logic [1:0] winner_o;
    logic       game_over_o, point_o;
    logic [15:0] score;
    logic       pt, pt_next;
    int         tests = 0;
    int         fails = 0;

    score_controller dut (
        .clk_1khz(clk_1khz), .rst_ni(rst_ni),
        .p1_btn_i(p1_btn_i), .p2_btn_i(p2_btn_i), .undo_btn_i(undo_btn_i),
        .p1_tens_o(p1_tens_o), .p1_ones_o(p1_ones_o),
        .p2_tens_o(p2_tens_o), .p2_ones_o(p2_ones_o),
        .winner_o(winner_o), .game_over_o(game_over_o), .point_o(point_o)
    );

    always #5 clk_1khz = ~clk_1khz;
    assign score = {p1_tens_o, p1_ones_o, p2_tens_o, p2_ones_o};

    task automatic do_reset();
        @(negedge clk_1khz);
        rst_ni = 1'b0; p1_btn_i = 1'b0; p2_btn_i = 1'b0; undo_btn_i = 1'b0;
        repeat (2) @(negedge clk_1khz);
        rst_ni = 1'b1;
    endtask

    // One press: pt captures point_o after the sampling edge, pt_next one cycle later
    task automatic press(input logic a, input logic b, input logic u);
        @(negedge clk_1khz);
        p1_btn_i = a; p2_btn_i = b; undo_btn_i = u;
        @(posedge clk_1khz); #1;
        pt = point_o;
        @(negedge clk_1khz);
        p1_btn_i = 1'b0; p2_btn_i = 1'b0; undo_btn_i = 1'b0;
        @(posedge clk_1khz); #1;
        pt_next = point_o;
        repeat (LOCKOUT) @(posedge clk_1khz);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if ({score, winner_o, game_over_o, point_o} !== {16'h0000, 2'b00, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset: score=%h win=%b go=%b pt=%b, required 0000/00/0/0",
                     score, winner_o, game_over_o, point_o);
        end
    endtask

    task automatic test_count();
        int pulses = 0;
        int long_pulses = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            press(1'b1, 1'b0, 1'b0);
            pulses += int'(pt);
            long_pulses += int'(pt_next);
            repeat (100) @(posedge clk_1khz);
        end
        tests++;
        if (score !== 16'h0300) begin
            fails++; $display("FAIL count_score: got %h required 0300", score);
        end
        tests++;
        if (pulses != 3 || long_pulses != 0) begin
            fails++; $display("FAIL count_pulses: got %0d/%0d required 3/0", pulses, long_pulses);
        end
        tests++;
        if (winner_o !== 2'b00) begin
            fails++; $display("FAIL count_winner: got %b required 00", winner_o);
        end
    endtask

    task automatic test_carry_lockout();
        do_reset();
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0, 1'b0);
        tests++;
        if (score !== 16'h0900) begin
            fails++; $display("FAIL carry_pre: got %h required 0900", score);
        end
        @(negedge clk_1khz); p1_btn_i = 1'b1;
        @(posedge clk_1khz); #1;
        tests++;
        if (score !== 16'h1000 || point_o !== 1'b1) begin
            fails++; $display("FAIL carry: got %h pt=%b required 1000 pt=1", score, point_o);
        end
        @(negedge clk_1khz); p1_btn_i = 1'b0;
        repeat (50) @(posedge clk_1khz);
        @(negedge clk_1khz); p1_btn_i = 1'b1;
        @(posedge clk_1khz); #1;
        tests++;
        if (score !== 16'h1000 || point_o !== 1'b0) begin
            fails++; $display("FAIL lockout: got %h pt=%b required 1000 pt=0", score, point_o);
        end
        @(negedge clk_1khz); p1_btn_i = 1'b0;
        repeat (LOCKOUT) @(posedge clk_1khz);
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        tests++;
        if (score !== 16'h0101) begin
            fails++; $display("FAIL simul_after_p1: got %h required 0101", score);
        end
        do_reset();
        press(1'b1, 1'b1, 1'b0);
        tests++;
        if (score !== 16'h0100 || pt !== 1'b1) begin
            fails++; $display("FAIL simul_from_reset: got %h pt=%b required 0100 pt=1", score, pt);
        end
    endtask

    task automatic test_win_undo();
        do_reset();
        for (int i = 0; i < 19; i++) begin
            press(1'b1, 1'b0, 1'b0);
            press(1'b0, 1'b1, 1'b0);
        end
        press(1'b1, 1'b0, 1'b0);
        tests++;
        if (score !== 16'h2019 || game_over_o !== 1'b0) begin
            fails++; $display("FAIL win_pre: got %h go=%b required 2019 go=0", score, game_over_o);
        end
        press(1'b1, 1'b0, 1'b0);
        tests++;
        if (score !== 16'h2119 || game_over_o !== 1'b1 || winner_o !== 2'b01 || pt !== 1'b1) begin
            fails++; $display("FAIL win: got %h go=%b win=%b pt=%b required 2119 1 01 1",
                              score, game_over_o, winner_o, pt);
        end
        press(1'b0, 1'b1, 1'b0);
        tests++;
        if (score !== 16'h2119 || pt !== 1'b0 || winner_o !== 2'b01) begin
            fails++; $display("FAIL game_over_ignore: got %h pt=%b win=%b required 2119 0 01",
                              score, pt, winner_o);
        end
        press(1'b0, 1'b0, 1'b1);
        tests++;
        if (score !== 16'h2019 || game_over_o !== 1'b0 || winner_o !== 2'b00) begin
            fails++; $display("FAIL win_undo: got %h go=%b win=%b required 2019 0 00",
                              score, game_over_o, winner_o);
        end
    endtask

    task automatic test_margin_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            press(1'b1, 1'b0, 1'b0);
            press(1'b0, 1'b1, 1'b0);
        end
        press(1'b1, 1'b0, 1'b0);
        tests++;
        if (score !== 16'h2120 || game_over_o !== 1'b0 || winner_o !== 2'b00) begin
            fails++; $display("FAIL margin_nowin: got %h go=%b win=%b required 2120 0 00",
                              score, game_over_o, winner_o);
        end
        press(1'b1, 1'b0, 1'b0);
        tests++;
        if (score !== 16'h2220 || game_over_o !== 1'b1 || winner_o !== 2'b01) begin
            fails++; $display("FAIL margin_win: got %h go=%b win=%b required 2220 1 01",
                              score, game_over_o, winner_o);
        end
        do_reset();
        for (int i = 0; i < 98; i++) begin
            press(1'b1, 1'b0, 1'b0);
            press(1'b0, 1'b1, 1'b0);
        end
        press(1'b1, 1'b0, 1'b0);
        tests++;
        if (score !== 16'h9998 || game_over_o !== 1'b0) begin
            fails++; $display("FAIL sat_pre: got %h go=%b required 9998 go=0", score, game_over_o);
        end
        press(1'b1, 1'b0, 1'b0);
        tests++;
        if (score !== 16'h9998 || pt !== 1'b0) begin
            fails++; $display("FAIL saturate: got %h pt=%b required 9998 pt=0", score, pt);
        end
        press(1'b0, 1'b0, 1'b1);
        tests++;
        if (score !== 16'h9898) begin
            fails++; $display("FAIL sat_last_kept: got %h required 9898", score);
        end
    endtask

    task automatic test_new_game();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press(1'b0, 1'b1, 1'b0);
            press(1'b1, 1'b0, 1'b0);
        end
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        tests++;
        if (score !== 16'h0507) begin
            fails++; $display("FAIL ng_pre: got %h required 0507", score);
        end
        @(negedge clk_1khz); undo_btn_i = 1'b1;
        @(posedge clk_1khz); #1;
        tests++;
        if (score !== 16'h0506 || point_o !== 1'b0) begin
            fails++; $display("FAIL ng_undo_rise: got %h pt=%b required 0506 pt=0", score, point_o);
        end
        repeat (1998) @(posedge clk_1khz);
        #1;
        tests++;
        if (score !== 16'h0506) begin
            fails++; $display("FAIL ng_early: got %h required 0506 at cycle 1998", score);
        end
        @(posedge clk_1khz); #1;
        tests++;
        if (score !== 16'h0000 || winner_o !== 2'b00 || game_over_o !== 1'b0) begin
            fails++; $display("FAIL ng_trigger: got %h win=%b go=%b required 0000 00 0",
                              score, winner_o, game_over_o);
        end
        repeat (300) @(posedge clk_1khz);
        @(negedge clk_1khz); p1_btn_i = 1'b1;
        @(posedge clk_1khz); #1;
        tests++;
        if (score !== 16'h0100 || point_o !== 1'b1) begin
            fails++; $display("FAIL ng_no_retrigger: got %h pt=%b required 0100 pt=1", score, point_o);
        end
        @(negedge clk_1khz); p1_btn_i = 1'b0;
        repeat (5) @(posedge clk_1khz);
        @(negedge clk_1khz); rst_ni = 1'b0;
        #1;
        tests++;
        if (score !== 16'h0000 || point_o !== 1'b0 || winner_o !== 2'b00) begin
            fails++; $display("FAIL ng_reset_mid_hold: got %h pt=%b win=%b required 0000 0 00",
                              score, point_o, winner_o);
        end
        undo_btn_i = 1'b0;
        @(negedge clk_1khz); rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry_lockout();
        test_simultaneous();
        test_win_undo();
        test_margin_saturation();
        test_new_game();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
